insn_fetch: RTL and testbench

- Instruction fetch unit sitting directly upstream of the IF/ID pipeline register.
- Generates sequential fetch addresses and issues them to instruction memory over a req/ack handshake, with one request outstanding at a time.
- Buffers returned words in a small prefetch FIFO and presents the head instruction and its PC to the IF/ID register.
- Handles stall back-pressure and redirects (flush or branch taken), including discarding a response that is still in flight.

---
 rtl/insn_fetch.sv | 176 +++++++++++++++++
 tb/tb_insn_fetch.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_fetch.sv
`default_nettype none
// ============================================================================
// Module   : insn_fetch
// Brief    : Sequential instruction fetch with one-outstanding req/ack memory
//            port, small prefetch FIFO and redirect/drop handling.
//            Optional perf counters enabled by defining FETCH_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module insn_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        insn_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_bubble_cnt,
    output logic [15:0] perf_drop_cnt
`endif
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t               r_state;
    logic [31:0]          r_fetch_pc;
    logic [31:0]          r_imem_addr;
    logic                 r_imem_req;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [31:0]          r_mem_pc   [FIFO_DEPTH];
    logic [31:0]          r_mem_insn [FIFO_DEPTH];

    logic [31:0]          w_redirect_pc;
    logic [31:0]          w_fetch_pc_inc;
    logic                 w_valid;
    logic                 w_pop;
    logic                 w_push;
    logic [c_CNT_W-1:0]   w_count_nxt;
    logic                 w_unused_bits;

    assign w_redirect_pc  = {redirect_pc[31:2], 2'b00};
    assign w_unused_bits  = &{1'b0, redirect_pc[1:0]};
    assign w_fetch_pc_inc = r_fetch_pc + 32'd4;
    assign w_valid        = (r_count != '0);
    assign w_pop          = w_valid && !stall && !redirect;
    // Push needs room; a same-cycle pop frees the head slot.
    assign w_push         = (r_state == ST_REQ) && imem_ack && !redirect
                            && ((r_count < c_DEPTH) || w_pop);
    assign w_count_nxt    = redirect ? '0
                          : r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_imem_addr;
    assign insn_valid = w_valid;
    assign insn       = w_valid ? r_mem_insn[r_rd_ptr] : NOP_INSN;
    assign insn_pc    = w_valid ? r_mem_pc[r_rd_ptr]   : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_imem_addr <= RESET_PC;
            r_imem_req  <= 1'b0;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end

            case (r_state)
                ST_IDLE: begin
                    if (redirect) begin
                        r_fetch_pc <= w_redirect_pc;
                    end else if (r_count < c_DEPTH) begin
                        r_state     <= ST_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= r_fetch_pc;
                    end
                end
                ST_REQ: begin
                    if (redirect) begin
                        r_fetch_pc <= w_redirect_pc;
                        if (imem_ack) begin
                            r_state    <= ST_IDLE;
                            r_imem_req <= 1'b0;
                        end else begin
                            // Old request stays on the bus until it is acked.
                            r_state <= ST_DROP;
                        end
                    end else if (w_push) begin
                        r_fetch_pc <= w_fetch_pc_inc;
                        if (w_count_nxt < c_DEPTH) begin
                            r_imem_addr <= w_fetch_pc_inc;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_imem_req <= 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    if (redirect) r_fetch_pc <= w_redirect_pc;
                    if (imem_ack) begin
                        r_state    <= ST_IDLE;
                        r_imem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Payload storage needs no reset: the count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
            r_mem_insn[r_wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_bubble_cnt;
    logic [15:0] r_drop_cnt;
    logic        w_drop_evt;

    assign w_drop_evt = imem_ack && ((r_state == ST_DROP)
                        || ((r_state == ST_REQ) && redirect));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bubble_cnt <= 32'h0;
            r_drop_cnt   <= 16'h0;
        end else begin
            if (!w_valid && !stall && !redirect && (r_bubble_cnt != 32'hFFFF_FFFF))
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            if (w_drop_evt && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign perf_bubble_cnt = r_bubble_cnt;
    assign perf_drop_cnt   = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_insn_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_insn_fetch
// Brief    : Self-checking bench for insn_fetch: directed table, corner-case
//            sequences and random traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_insn_fetch;

    localparam int          c_DEPTH = 2;
    localparam logic [31:0] c_RST   = 32'h0000_0000;
    localparam logic [31:0] c_NOP   = 32'h0000_0013;
    localparam int          M_IDLE  = 0;
    localparam int          M_REQ   = 1;
    localparam int          M_DROP  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubble_cnt;
    logic [15:0] perf_drop_cnt;
    logic [31:0] m_bubble;
    logic [15:0] m_drop;
`endif

    insn_fetch #(
        .RESET_PC   (c_RST),
        .FIFO_DEPTH (c_DEPTH),
        .NOP_INSN   (c_NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .insn        (insn),
        .insn_pc     (insn_pc),
        .insn_valid  (insn_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_drop_cnt   (perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: FIFO is a queue of {pc, insn}; state is a plain int.
    int          m_st;
    logic [31:0] m_pc;
    logic [31:0] m_drop_addr;
    logic [63:0] m_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE;
        m_pc = c_RST;
        m_drop_addr = c_RST;
        m_q.delete();
`ifdef FETCH_PERF_EN
        m_bubble = 32'h0;
        m_drop   = 16'h0;
`endif
    endtask

    task automatic model_update();
        int  sz0;
        int  nst;
        logic pop;
        logic push;
        sz0  = m_q.size();
        pop  = (sz0 != 0) && !stall && !redirect;
        push = (m_st == M_REQ) && imem_ack && !redirect;
        nst  = m_st;
`ifdef FETCH_PERF_EN
        if (sz0 == 0 && !stall && !redirect && m_bubble != 32'hFFFF_FFFF) m_bubble++;
        if (imem_ack && (m_st == M_DROP || (m_st == M_REQ && redirect)) && m_drop != 16'hFFFF)
            m_drop++;
`endif
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back({m_pc, imem_rdata});
            m_pc = m_pc + 32'd4;
        end
        case (m_st)
            M_IDLE:  if (!redirect && sz0 < c_DEPTH) nst = M_REQ;
            M_REQ: begin
                if (redirect) begin
                    nst = imem_ack ? M_IDLE : M_DROP;
                    m_drop_addr = m_pc;
                end else if (imem_ack) begin
                    nst = (m_q.size() < c_DEPTH) ? M_REQ : M_IDLE;
                end
            end
            default: if (imem_ack) nst = M_IDLE;
        endcase
        if (redirect) begin
            m_q.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end
        m_st = nst;
    endtask

    task automatic check_model();
        logic [63:0] head;
        logic        e_v;
        e_v  = (m_q.size() != 0);
        head = e_v ? m_q[0] : {32'h0, c_NOP};
        chk("imem_req", 32'(imem_req), 32'(m_st != M_IDLE));
        if (m_st != M_IDLE)
            chk("imem_addr", imem_addr, (m_st == M_DROP) ? m_drop_addr : m_pc);
        chk("insn_valid", 32'(insn_valid), 32'(e_v));
        chk("insn", insn, head[31:0]);
        chk("insn_pc", insn_pc, head[63:32]);
`ifdef FETCH_PERF_EN
        chk("perf_bubble_cnt", perf_bubble_cnt, m_bubble);
        chk("perf_drop_cnt", 32'(perf_drop_cnt), 32'(m_drop));
`endif
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] rpc, input logic a);
        @(negedge clk);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        imem_ack    = a;
        imem_rdata  = $urandom();
        #2;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    typedef struct {
        logic        stall;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'd4,  1'b1, 32'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'd8,  1'b1, 32'd4};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'd12, 1'b1, 32'd8};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd12};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 32'd12};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 32'd12};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 32'd12};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 32'd12};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'd0,  1'b1, 32'd12};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 32'd0,  1'b1, 32'd16};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 32'd20, 1'b0, 32'd0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 32'd24, 1'b1, 32'd20};

        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("rst imem_req", 32'(imem_req), 32'd0);
        chk("rst imem_addr", imem_addr, c_RST);
        chk("rst insn", insn, c_NOP);
        chk("rst insn_pc", insn_pc, 32'd0);
        chk("rst insn_valid", 32'(insn_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Streaming, then a 5-cycle stall filling the FIFO.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].stall, 1'b0, 32'h0, tbl[i].ack);
            chk("tbl imem_req", 32'(imem_req), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req) chk("tbl imem_addr", imem_addr, tbl[i].exp_addr);
            chk("tbl insn_valid", 32'(insn_valid), 32'(tbl[i].exp_valid));
            chk("tbl insn_pc", insn_pc, tbl[i].exp_pc);
            tick();
        end

        // Redirect with request pending, ack three cycles later.
        step(1'b0, 1'b1, 32'h100, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, i == 2);
            chk("drop imem_req", 32'(imem_req), 32'd1);
            chk("drop imem_addr", imem_addr, 32'h1C);
            chk("drop insn_valid", 32'(insn_valid), 32'd0);
            tick();
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("post-drop idle", 32'(imem_req), 32'd0);
        chk("post-drop valid", 32'(insn_valid), 32'd0);
        tick();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir addr", imem_addr, 32'h100);
        tick();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir valid", 32'(insn_valid), 32'd1);
        chk("redir insn_pc", insn_pc, 32'h100);
        tick();

        // Redirect coinciding with ack: word dropped, aligned restart.
        step(1'b0, 1'b1, 32'h203, 1'b1); tick();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("ackredir valid", 32'(insn_valid), 32'd0);
        chk("ackredir req", 32'(imem_req), 32'd0);
        tick();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("ackredir addr", imem_addr, 32'h200);
        chk("ackredir req1", 32'(imem_req), 32'd1);
        tick();

        // Address wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0); tick();
        step(1'b0, 1'b0, 32'h0, 1'b1); tick();
        step(1'b0, 1'b0, 32'h0, 1'b1); tick();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap addr1", imem_addr, 32'h0);
        chk("wrap insn_pc", insn_pc, 32'hFFFF_FFFC);
        tick();

        // Asynchronous reset while a request is outstanding.
        step(1'b1, 1'b0, 32'h0, 1'b0); tick();
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async imem_req", 32'(imem_req), 32'd0);
        chk("async insn_valid", 32'(insn_valid), 32'd0);
        chk("async imem_addr", imem_addr, c_RST);
        chk("async insn", insn, c_NOP);
`ifdef FETCH_PERF_EN
        chk("async perf_bubble", perf_bubble_cnt, 32'd0);
        chk("async perf_drop", 32'(perf_drop_cnt), 32'd0);
`endif
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("restart idle", 32'(imem_req), 32'd0);
        tick();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("restart req", 32'(imem_req), 32'd1);
        chk("restart addr", imem_addr, c_RST);
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 10) < 3, ($urandom % 20) == 0, $urandom, ($urandom % 10) < 6);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
